dma_mem_sched: RTL and testbench
================================

// Module: dma_mem_sched
// PURPOSE
//  Two-channel DMA scheduler sharing the single-port 32-bit word memory (192 x 32).
//  Each channel copies LEN words from SRC to DST through one memory port.
//  A round-robin arbiter grants the port to one channel at a time.
//  Sits between the DMA register front-end and the memory block; it is the only master driving mem_wr/mem_addr.
// PARAMETERS
//  AW        8    memory address width
//  DW        32   memory data width
//  MEM_DEPTH 192  valid words; an address >= MEM_DEPTH is illegal
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  ch_start    in   2   per-channel start pulse, 1 cycle
//  ch_src0     in   AW  channel 0 source address, sampled at grant
//  ch_dst0     in   AW  channel 0 destination address, sampled at grant
//  ch_len0     in   AW  channel 0 word count, sampled at grant
//  ch_src1     in   AW  channel 1 source address
//  ch_dst1     in   AW  channel 1 destination address
//  ch_len1     in   AW  channel 1 word count
//  ch_busy     out  2   channel pending or active
//  ch_done     out  2   1-cycle pulse at channel completion
//  ch_err      out  2   sticky; set on range violation, cleared by next ch_start of that channel
//  mem_wr      out  1   1 = write cycle, 0 = read cycle
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  write data, valid when mem_wr=1
//  mem_rdata   in   DW  read data, valid 1 cycle after a read address
// BEHAVIOUR
//  Reset: state=IDLE; ch_busy=0, ch_done=0, ch_err=0, mem_wr=0, mem_addr=0, mem_wdata=0, rr_ptr=0 (ch0 favoured).
//  ch_start[i] sets pending[i] and clears ch_err[i]; ch_start on a busy channel is ignored.
//  FSM states: IDLE, GRANT, RD, CAP, WR, DONE.
//   IDLE  -> GRANT when any pending[i] is set.
//   GRANT: select a channel; latch src/dst/len into working counters.
//          len == 0 -> DONE, no memory access.
//          src or dst >= MEM_DEPTH -> set ch_err, go to DONE.
//          Otherwise -> RD.
//   RD    mem_addr=src, mem_wr=0 -> CAP.
//   CAP   latch mem_rdata into mem_wdata -> WR.
//   WR    mem_addr=dst, mem_wr=1; then src++, dst++, len--.
//         len becomes 0 -> DONE.
//         Next src or dst == MEM_DEPTH -> set ch_err, go to DONE; no address wrap.
//         Otherwise -> RD.
//   DONE  ch_done[g] pulses for 1 cycle; pending[g] cleared; rr_ptr = ~g -> IDLE.
//  Arbitration: round-robin. On simultaneous pending requests, the channel rr_ptr points to wins.
//          A lone request wins regardless of rr_ptr.
//          No preemption: a granted channel runs to completion.
//  Latency:
//   ch_start -> first RD = 3 cycles (IDLE, GRANT, RD).
//   Each word = 3 cycles (RD, CAP, WR).
//   N-word transfer: ch_start to ch_done pulse = 3N+3 cycles.
//  mem_wr is high only in WR; all other states drive 0, so the memory never writes spuriously.
//  Counters are AW-bit; len is unsigned, so 0..255 words are legal in the counter.
//  The range check bounds every actual access to < MEM_DEPTH.
//  Reset mid-transfer: all state is abandoned immediately; no done pulse; mem_wr=0.
//  A partially copied destination stays as written.
// CONFIGURATION
//  DMA_IRQ_EN defined:
//   adds output irq (1 bit), registered.
//   irq is set on any ch_done pulse.
//   irq is held until irq_ack (input, 1 bit) is high for one cycle.
//   If ack and a new done coincide, set wins.
//   irq resets to 0.
//  DMA_IRQ_EN undefined: irq and irq_ack ports do not exist; completion is signalled only via ch_done.
// TESTING
//  1. Preload mem[1..3]=8,9,12.
//     ch0 src=1 dst=100 len=3 -> mem[100..102]=8,9,12.
//     ch_done[0] pulses 12 cycles after start; ch_err=0.
//  2. ch_start=2'b11 in the same cycle (ch0 len=2, ch1 len=2) -> ch0 served first, then ch1.
//     Repeat with rr_ptr=1 -> ch1 served first.
//  3. ch0 len=0 -> ch_done[0] pulses 3 cycles after start; mem_wr never asserted.
//  4. ch1 src=190 dst=10 len=4 -> mem[10..11] copied, then ch_err[1]=1 and ch_done[1] pulses.
//     mem_addr never reaches 192.
//  5. Assert rst_n=0 during the CAP cycle of word 2 -> outputs return to reset values asynchronously.
//     After release, a new start completes normally.
//  6. DMA_IRQ_EN build: two transfers complete before any ack -> irq stays 1.
//     Pulse irq_ack -> irq=0 on the next cycle.

Source files
------------

// File: rtl/dma_mem_sched.sv
// Two-channel round-robin DMA copy engine that drives a single-port word memory.
// Define DMA_IRQ_EN to add a registered completion interrupt (irq, cleared by irq_ack).
module dma_mem_sched #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int MEM_DEPTH = 192
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ch_start,
    input  logic [AW-1:0] ch_src0,
    input  logic [AW-1:0] ch_dst0,
    input  logic [AW-1:0] ch_len0,
    input  logic [AW-1:0] ch_src1,
    input  logic [AW-1:0] ch_dst1,
    input  logic [AW-1:0] ch_len1,
    output logic [1:0]    ch_busy,
    output logic [1:0]    ch_done,
    output logic [1:0]    ch_err,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMA_IRQ_EN
    ,
    input  logic          irq_ack,
    output logic          irq
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AW:0] DEPTH = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    pending_q, pending_d;
    logic [1:0]    err_q, err_d;
    logic          rr_q, rr_d;
    logic          g_q, g_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          sel;
    logic [AW-1:0] gsrc, gdst, glen;
    logic [AW:0]   src_inc, dst_inc;

    // Both pending: rr_q picks; a lone request wins outright.
    assign sel     = (pending_q == 2'b11) ? rr_q : pending_q[1];
    assign gsrc    = sel ? ch_src1 : ch_src0;
    assign gdst    = sel ? ch_dst1 : ch_dst0;
    assign glen    = sel ? ch_len1 : ch_len0;
    assign src_inc = {1'b0, src_q} + ONE;
    assign dst_inc = {1'b0, dst_q} + ONE;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        err_d     = err_q;
        rr_d      = rr_q;
        g_d       = g_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        wdata_d   = wdata_q;

        for (int unsigned i = 0; i < 2; i++) begin
            if (ch_start[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                err_d[i]     = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|pending_q) state_d = S_GRANT;
            end
            S_GRANT: begin
                g_d   = sel;
                src_d = gsrc;
                dst_d = gdst;
                len_d = glen;
                if (glen == '0) begin
                    state_d = S_DONE;
                end else if ({1'b0, gsrc} >= DEPTH || {1'b0, gdst} >= DEPTH) begin
                    err_d[sel] = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                wdata_d = mem_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                src_d = src_inc[AW-1:0];
                dst_d = dst_inc[AW-1:0];
                len_d = len_q - ONE[AW-1:0];
                // Completion beats the range stop, so a copy ending on the last word is clean.
                if (len_q == ONE[AW-1:0]) begin
                    state_d = S_DONE;
                end else if (src_inc == DEPTH || dst_inc == DEPTH) begin
                    err_d[g_q] = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                pending_d[g_q] = 1'b0;
                rr_d           = ~g_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            err_q     <= '0;
            rr_q      <= 1'b0;
            g_q       <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (state_q == S_RD)      mem_addr = src_q;
        else if (state_q == S_WR) mem_addr = dst_q;
    end

    assign mem_wr    = (state_q == S_WR);
    assign mem_wdata = wdata_q;
    assign ch_busy   = pending_q;
    assign ch_err    = err_q;
    assign ch_done   = (state_q == S_DONE) ? {g_q, ~g_q} : 2'b00;

`ifdef DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          irq_q <= 1'b0;
        else if (|ch_done)   irq_q <= 1'b1;
        else if (irq_ack)    irq_q <= 1'b0;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_mem_sched.sv
// Bench for dma_mem_sched: word memory model plus a copy-semantics reference model.
// Directed cases followed by randomized single and simultaneous transfers.
module tb_dma_mem_sched;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    ch_start = 2'b00;
    logic [AW-1:0] ch_src0 = '0, ch_dst0 = '0, ch_len0 = '0;
    logic [AW-1:0] ch_src1 = '0, ch_dst1 = '0, ch_len1 = '0;
    logic [1:0]    ch_busy, ch_done, ch_err;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DMA_IRQ_EN
    logic          irq_ack = 1'b0;
    logic          irq;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          wr_count = 0;
    int          bad_addr = 0;
    logic        sync_req = 1'b0;
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    bit          rr = 1'b0;

    dma_mem_sched #(.AW(AW), .DW(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ch_start(ch_start),
        .ch_src0(ch_src0), .ch_dst0(ch_dst0), .ch_len0(ch_len0),
        .ch_src1(ch_src1), .ch_dst1(ch_dst1), .ch_len1(ch_len1),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMA_IRQ_EN
        , .irq_ack(irq_ack), .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port memory; sync_req reloads it from the reference image.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
        if (rst_n && int'(mem_addr) >= DEPTH) bad_addr <= bad_addr + 1;
        if (sync_req) for (int k = 0; k < 256; k++) mem[k] <= ref_mem[k];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_chk(input string tag);
        int m = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) m++;
        chk(tag, 64'(m), 64'd0);
    endtask

    task automatic do_sync();
        @(negedge clk); sync_req = 1'b1;
        @(negedge clk); sync_req = 1'b0;
    endtask

    // Word-by-word copy in order; stops before any address would leave the memory.
    task automatic model_copy(input int src, input int dst, input int len,
                              output int copied, output bit err);
        copied = 0;
        for (int k = 0; k < len; k++) begin
            if (src + k >= DEPTH || dst + k >= DEPTH) break;
            ref_mem[dst + k] = ref_mem[src + k];
            copied++;
        end
        err = (len != 0) && (copied < len);
    endtask

    task automatic set_regs(input int ch, input int src, input int dst, input int len);
        if (ch == 0) begin
            ch_src0 = AW'(src); ch_dst0 = AW'(dst); ch_len0 = AW'(len);
        end else begin
            ch_src1 = AW'(src); ch_dst1 = AW'(dst); ch_len1 = AW'(len);
        end
    endtask

    task automatic wait_done(input int ch, input int repulse);
        int n = 0;
        while (ch_done == 2'b00 && n < 3000) begin
            @(negedge clk);
            n++;
            ch_start = (repulse != 0 && n == repulse) ? (2'b01 << ch) : 2'b00;
        end
        ch_start = 2'b00;
        chk("done_seen", 64'(ch_done != 2'b00), 64'd1);
    endtask

    task automatic run_single(input int ch, input int src, input int dst, input int len,
                              input int repulse, input string tag);
        int  copied, t0, wc0, extra;
        bit  err;
        set_regs(ch, src, dst, len);
        model_copy(src, dst, len, copied, err);
        @(negedge clk);
        ch_start = 2'b01 << ch;
        t0  = int'(cyc);
        wc0 = wr_count;
        @(negedge clk);
        ch_start = 2'b00;
        chk({tag, "_busy"}, 64'(ch_busy[ch]), 64'd1);
        chk({tag, "_errclr"}, 64'(ch_err[ch]), 64'd0);
        wait_done(ch, repulse);
        chk({tag, "_who"}, 64'(ch_done), 64'(2'b01 << ch));
        chk({tag, "_lat"}, 64'(int'(cyc) - t0), 64'(3 * copied + 3));
        chk({tag, "_err"}, 64'(ch_err[ch]), 64'(err));
        rr = (ch == 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(ch_done), 64'd0);
        chk({tag, "_idle"}, 64'(ch_busy), 64'd0);
        chk({tag, "_wrs"}, 64'(wr_count - wc0), 64'(copied));
        mem_chk({tag, "_mem"});
        if (repulse != 0) begin
            extra = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (ch_done != 2'b00 || ch_busy != 2'b00) extra++;
            end
            chk({tag, "_ignored"}, 64'(extra), 64'd0);
        end
    endtask

    task automatic run_dual(input int s0, input int d0, input int l0,
                            input int s1, input int d1, input int l1, input string tag);
        int sp[2], dp[2], lp[2], c[2];
        bit e[2];
        int first, second, t0, wc0;
        sp[0] = s0; dp[0] = d0; lp[0] = l0;
        sp[1] = s1; dp[1] = d1; lp[1] = l1;
        set_regs(0, s0, d0, l0);
        set_regs(1, s1, d1, l1);
        first  = rr ? 1 : 0;
        second = 1 - first;
        model_copy(sp[first], dp[first], lp[first], c[first], e[first]);
        model_copy(sp[second], dp[second], lp[second], c[second], e[second]);
        @(negedge clk);
        ch_start = 2'b11;
        t0  = int'(cyc);
        wc0 = wr_count;
        @(negedge clk);
        ch_start = 2'b00;
        chk({tag, "_busy"}, 64'(ch_busy), 64'd3);
        wait_done(first, 0);
        chk({tag, "_first"}, 64'(ch_done), 64'(2'b01 << first));
        chk({tag, "_lat1"}, 64'(int'(cyc) - t0), 64'(3 * c[first] + 3));
        chk({tag, "_err1"}, 64'(ch_err[first]), 64'(e[first]));
        @(negedge clk);
        wait_done(second, 0);
        chk({tag, "_second"}, 64'(ch_done), 64'(2'b01 << second));
        chk({tag, "_lat2"}, 64'(int'(cyc) - t0), 64'(3 * c[first] + 3 * c[second] + 6));
        chk({tag, "_err2"}, 64'(ch_err[second]), 64'(e[second]));
        rr = (second == 0);
        @(negedge clk);
        chk({tag, "_idle"}, 64'(ch_busy), 64'd0);
        chk({tag, "_wrs"}, 64'(wr_count - wc0), 64'(c[0] + c[1]));
        mem_chk({tag, "_mem"});
    endtask

    initial begin
        int t0, n, s, d, l, cp;
        bit e;

        for (int k = 0; k < 256; k++) ref_mem[k] = $urandom;
        #2 rst_n = 1'b0;
        do_sync();
        @(negedge clk);
        chk("rst_busy", 64'(ch_busy), 64'd0);
        chk("rst_done", 64'(ch_done), 64'd0);
        chk("rst_err", 64'(ch_err), 64'd0);
        chk("rst_wr", 64'(mem_wr), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;

        // Basic copy with known data.
        ref_mem[1] = 32'd8; ref_mem[2] = 32'd9; ref_mem[3] = 32'd12;
        do_sync();
        run_single(0, 1, 100, 3, 0, "t1");
        chk("t1_m100", 64'(mem[100]), 64'd8);
        chk("t1_m101", 64'(mem[101]), 64'd9);
        chk("t1_m102", 64'(mem[102]), 64'd12);

        // Round-robin: bring the pointer to ch0, then to ch1.
        run_single(1, 20, 30, 1, 0, "t2a");
        run_dual(40, 50, 2, 60, 70, 2, "t2b");
        run_single(0, 80, 90, 1, 0, "t2c");
        run_dual(110, 120, 2, 130, 140, 2, "t2d");

        // Zero length, restart while busy, range stops and boundaries.
        run_single(0, 5, 50, 0, 0, "t3");
        run_single(0, 30, 60, 2, 3, "ign");
        run_single(1, 190, 10, 4, 0, "t4");
        chk("t4_errvec", 64'(ch_err), 64'd2);
        run_single(0, 200, 5, 3, 0, "gsrc");
        run_single(1, 5, 192, 3, 0, "gdst");
        run_single(0, 185, 188, 6, 0, "wdst");
        run_single(1, 189, 20, 3, 0, "edge");
        run_single(0, 10, 15, 8, 0, "ovl");

        // Reset during the capture cycle of the second word.
        set_regs(0, 20, 40, 4);
        @(negedge clk);
        ch_start = 2'b01;
        t0 = int'(cyc);
        @(negedge clk);
        ch_start = 2'b00;
        n = 0;
        while (int'(cyc) - t0 < 7 && n < 100) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        chk("r5_busy", 64'(ch_busy), 64'd0);
        chk("r5_done", 64'(ch_done), 64'd0);
        chk("r5_wr", 64'(mem_wr), 64'd0);
        chk("r5_addr", 64'(mem_addr), 64'd0);
        chk("r5_wdata", 64'(mem_wdata), 64'd0);
        ref_mem[40] = ref_mem[20];
        rr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_chk("r5_partial");
        run_single(0, 20, 40, 4, 0, "r5_after");

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_dual($urandom_range(0, 199), $urandom_range(0, 199), $urandom_range(0, 12),
                         $urandom_range(0, 199), $urandom_range(0, 199), $urandom_range(0, 12), "rdual");
            end else begin
                s = $urandom_range(0, 199);
                d = $urandom_range(0, 199);
                l = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
                run_single($urandom_range(0, 1), s, d, l, 0, "rsgl");
            end
        end

`ifdef DMA_IRQ_EN
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_clr0", 64'(irq), 64'd0);
        run_single(0, 1, 2, 1, 0, "irq_a");
        run_single(1, 3, 4, 1, 0, "irq_b");
        chk("irq_held", 64'(irq), 64'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack", 64'(irq), 64'd0);
        set_regs(0, 0, 0, 0);
        model_copy(0, 0, 0, cp, e);
        @(negedge clk);
        ch_start = 2'b01;
        @(negedge clk);
        ch_start = 2'b00;
        wait_done(0, 0);
        rr = 1'b1;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_setwins", 64'(irq), 64'd1);
`endif

        chk("addr_range", 64'(bad_addr), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
